// File: rtl/clock_set_controller_pkg.sv
// Shared encodings, field layout and range helpers for the clock/date setting sequencer.
package clock_set_controller_pkg;

  localparam int TIME_W = 17;
  localparam int DATE_W = 21;

  // Bit positions inside the packed time {hour,min,sec} and date {day,month,year} words
  localparam int HOUR_LSB  = 12;
  localparam int MIN_LSB   = 6;
  localparam int SEC_LSB   = 0;
  localparam int DAY_LSB   = 16;
  localparam int MONTH_LSB = 12;
  localparam int YEAR_LSB  = 0;

  localparam logic [5:0] HOUR_MAX  = 6'd23;
  localparam logic [5:0] MIN_MAX   = 6'd59;
  localparam logic [5:0] SEC_MAX   = 6'd59;
  localparam logic [3:0] MONTH_MAX = 4'd12;

  localparam logic [DATE_W-1:0] DATE_RST = {5'd1, 4'd1, 12'd0};

  typedef enum logic [2:0] {
    FLD_HOUR  = 3'd0,
    FLD_MIN   = 3'd1,
    FLD_SEC   = 3'd2,
    FLD_DAY   = 3'd3,
    FLD_MONTH = 3'd4,
    FLD_YEAR  = 3'd5
  } field_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_EDIT   = 2'd1,
    ST_COMMIT = 2'd2
  } state_e;

  // Wrapping step for 0..vmax fields; anything above vmax normalises to 0.
  function automatic logic [5:0] step_hms(input logic [5:0] v, input logic [5:0] vmax,
                                          input logic up);
    logic [5:0] r;
    if (v > vmax)    r = 6'd0;
    else if (up)     r = (v == vmax) ? 6'd0 : v + 6'd1;
    else             r = (v == 6'd0) ? vmax : v - 6'd1;
    return r;
  endfunction

  // Wrapping step for 1..dim day-of-month; day 0 normalises to 1.
  function automatic logic [4:0] step_day(input logic [4:0] d, input logic [4:0] dim,
                                          input logic up);
    logic [4:0] r;
    if (d == 5'd0)   r = 5'd1;
    else if (up)     r = (d >= dim) ? 5'd1 : d + 5'd1;
    else if (d == 5'd1) r = dim;
    else             r = (d > dim) ? dim : d - 5'd1;
    return r;
  endfunction

  function automatic logic [3:0] step_month(input logic [3:0] m, input logic up);
    logic [3:0] r;
    if (m == 4'd0)   r = 4'd1;
    else if (up)     r = (m >= MONTH_MAX) ? 4'd1 : m + 4'd1;
    else if (m == 4'd1) r = MONTH_MAX;
    else             r = (m > MONTH_MAX) ? MONTH_MAX : m - 4'd1;
    return r;
  endfunction

endpackage

// File: rtl/clock_set_controller_month_length.sv
// Days in a month for a given Gregorian year; pure combinational, shared with the calendar counter.
module month_length (
  input  logic [3:0]  month,
  input  logic [11:0] year,
  output logic [4:0]  dim
);

  logic leap;

  always_comb begin
    leap = (year[1:0] == 2'b00) &&
           (((year % 12'd100) != 12'd0) || ((year % 12'd400) == 12'd0));
    case (month)
      4'd4, 4'd6, 4'd9, 4'd11: dim = 5'd30;
      4'd2:                    dim = leap ? 5'd29 : 5'd28;
      default:                 dim = 5'd31;
    endcase
  end

endmodule

// File: rtl/clock_set_controller.sv
// Button-driven editor for the running time/date; commits the edited values with overwrite strobes.
module clock_set_controller
  import clock_set_controller_pkg::*;
#(
  parameter int unsigned OW_CYCLES    = 4,
  parameter int unsigned EDIT_TIMEOUT = 100000000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              edit_btn,
  input  logic              next_btn,
  input  logic              inc_btn,
  input  logic              dec_btn,
  input  logic [TIME_W-1:0] time_cur,
  input  logic [DATE_W-1:0] date_cur,
  output logic [TIME_W-1:0] time_set,
  output logic [DATE_W-1:0] date_set,
  output logic              time_ow,
  output logic              date_ow,
  output logic              editing,
  output logic [2:0]        field
);

  localparam int TMO_W = $clog2(EDIT_TIMEOUT + 1);
  localparam int OW_W  = $clog2(OW_CYCLES + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(EDIT_TIMEOUT - 1);
  localparam logic [OW_W-1:0]  OW_LAST  = OW_W'(OW_CYCLES - 1);

  state_e              state_q, state_d;
  field_e              field_q, field_d;
  logic [TIME_W-1:0]   time_q, time_d, time_edit;
  logic [DATE_W-1:0]   date_q, date_d, date_edit;
  logic [TMO_W-1:0]    tmo_q, tmo_d;
  logic [OW_W-1:0]     ow_q, ow_d;

  logic [4:0]  hour_cur, day_cur, dim_cur, dim_new;
  logic [5:0]  min_cur, sec_cur, hms_step;
  logic [3:0]  mon_cur, mon_new;
  logic [11:0] yr_cur, yr_new;

  assign hour_cur = time_q[HOUR_LSB +: 5];
  assign min_cur  = time_q[MIN_LSB +: 6];
  assign sec_cur  = time_q[SEC_LSB +: 6];
  assign day_cur  = date_q[DAY_LSB +: 5];
  assign mon_cur  = date_q[MONTH_LSB +: 4];
  assign yr_cur   = date_q[YEAR_LSB +: 12];

  // Candidate month/year after this cycle's step, so the day clamp uses the new calendar.
  assign mon_new = (field_q == FLD_MONTH) ? step_month(mon_cur, inc_btn) : mon_cur;
  assign yr_new  = (field_q == FLD_YEAR) ? (inc_btn ? yr_cur + 12'd1 : yr_cur - 12'd1)
                                         : yr_cur;

  month_length u_dim_cur (.month(mon_cur), .year(yr_cur), .dim(dim_cur));
  month_length u_dim_new (.month(mon_new), .year(yr_new), .dim(dim_new));

  always_comb begin
    time_edit = time_q;
    date_edit = date_q;
    hms_step  = 6'd0;
    case (field_q)
      FLD_HOUR: begin
        hms_step = step_hms({1'b0, hour_cur}, HOUR_MAX, inc_btn);
        time_edit[HOUR_LSB +: 5] = hms_step[4:0];
      end
      FLD_MIN:  time_edit[MIN_LSB +: 6] = step_hms(min_cur, MIN_MAX, inc_btn);
      FLD_SEC:  time_edit[SEC_LSB +: 6] = step_hms(sec_cur, SEC_MAX, inc_btn);
      FLD_DAY:  date_edit[DAY_LSB +: 5] = step_day(day_cur, dim_cur, inc_btn);
      FLD_MONTH, FLD_YEAR: begin
        date_edit[MONTH_LSB +: 4] = mon_new;
        date_edit[YEAR_LSB +: 12] = yr_new;
        if (day_cur > dim_new) date_edit[DAY_LSB +: 5] = dim_new;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    field_d = field_q;
    time_d  = time_q;
    date_d  = date_q;
    tmo_d   = tmo_q;
    ow_d    = ow_q;
    case (state_q)
      ST_IDLE: begin
        tmo_d = '0;
        ow_d  = '0;
        if (edit_btn) begin
          time_d  = time_cur;
          date_d  = date_cur;
          field_d = FLD_HOUR;
          state_d = ST_EDIT;
        end
      end
      ST_EDIT: begin
        if (edit_btn) begin
          state_d = ST_IDLE;
          field_d = FLD_HOUR;
          tmo_d   = '0;
        end else if (next_btn) begin
          tmo_d = '0;
          if (field_q == FLD_YEAR) begin
            state_d = ST_COMMIT;
            field_d = FLD_HOUR;
            ow_d    = '0;
          end else begin
            field_d = field_e'(field_q + 3'd1);
          end
        end else if (inc_btn || dec_btn) begin
          tmo_d = '0;
          if (inc_btn != dec_btn) begin
            time_d = time_edit;
            date_d = date_edit;
          end
        end else if (tmo_q == TMO_LAST) begin
          state_d = ST_IDLE;
          field_d = FLD_HOUR;
          tmo_d   = '0;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      ST_COMMIT: begin
        if (ow_q == OW_LAST) begin
          state_d = ST_IDLE;
          ow_d    = '0;
        end else begin
          ow_d = ow_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      field_q <= FLD_HOUR;
      time_q  <= '0;
      date_q  <= DATE_RST;
      tmo_q   <= '0;
      ow_q    <= '0;
    end else begin
      state_q <= state_d;
      field_q <= field_d;
      time_q  <= time_d;
      date_q  <= date_d;
      tmo_q   <= tmo_d;
      ow_q    <= ow_d;
    end
  end

  // Strobes and mode flag come straight from the state register, so reset drops them at once.
  assign time_set = time_q;
  assign date_set = date_q;
  assign time_ow  = (state_q == ST_COMMIT);
  assign date_ow  = (state_q == ST_COMMIT);
  assign editing  = (state_q == ST_EDIT);
  assign field    = field_q;

endmodule

// File: tb/tb_clock_set_controller.sv
// Directed bench for clock_set_controller with hand-computed expected time/date words.
module tb_clock_set_controller;

  localparam int OWC = 4;
  localparam int TMO = 20;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        edit_btn = 1'b0, next_btn = 1'b0, inc_btn = 1'b0, dec_btn = 1'b0;
  logic [16:0] time_cur = '0;
  logic [20:0] date_cur = '0;
  logic [16:0] time_set;
  logic [20:0] date_set;
  logic        time_ow, date_ow, editing;
  logic [2:0]  field;

  int n_chk = 0;
  int n_bad = 0;
  int ow_seen = 0;
  int ow_mark;

  clock_set_controller #(.OW_CYCLES(OWC), .EDIT_TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .edit_btn(edit_btn), .next_btn(next_btn), .inc_btn(inc_btn), .dec_btn(dec_btn),
    .time_cur(time_cur), .date_cur(date_cur),
    .time_set(time_set), .date_set(date_set),
    .time_ow(time_ow), .date_ow(date_ow),
    .editing(editing), .field(field)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (time_ow || date_ow) ow_seen++;

  function automatic logic [16:0] tp(input int h, input int m, input int s);
    return {5'(h), 6'(m), 6'(s)};
  endfunction

  function automatic logic [20:0] dp(input int d, input int mo, input int y);
    return {5'(d), 4'(mo), 12'(y)};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Buttons change on the falling edge; returns on the falling edge after the capturing rise.
  task automatic press(input bit e, input bit n, input bit i, input bit d);
    @(negedge clk);
    edit_btn = e; next_btn = n; inc_btn = i; dec_btn = d;
    @(negedge clk);
    edit_btn = 0; next_btn = 0; inc_btn = 0; dec_btn = 0;
  endtask

  task automatic nexts(input int k);
    for (int j = 0; j < k; j++) press(0, 1, 0, 0);
  endtask

  task automatic commit_strobes(input string tag);
    for (int j = 0; j < OWC; j++) begin
      chk({tag, "_ow_hi"}, {time_ow, date_ow}, 2'b11);
      if (j < OWC - 1) @(negedge clk);
    end
    @(negedge clk);
    chk({tag, "_ow_lo"}, {time_ow, date_ow}, 2'b00);
    chk({tag, "_editing"}, editing, 1'b0);
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_time", time_set, 17'd0);
    chk("rst_date", date_set, dp(1, 1, 0));
    chk("rst_flags", {time_ow, date_ow, editing, field}, 6'd0);
    rst = 0;

    // Hour wrap and full commit
    time_cur = tp(23, 48, 0); date_cur = dp(15, 1, 2020);
    press(1, 0, 0, 0);
    chk("snap_editing", editing, 1'b1);
    chk("snap_time", time_set, tp(23, 48, 0));
    press(0, 0, 1, 0);
    chk("hour_wrap", time_set, tp(0, 48, 0));
    nexts(5);
    chk("field_year", field, 3'd5);
    nexts(1);
    chk("commit_field", field, 3'd0);
    commit_strobes("c1");
    chk("c1_time", time_set, tp(0, 48, 0));
    chk("c1_date", date_set, dp(15, 1, 2020));

    // Minute wrap on decrement
    time_cur = tp(10, 0, 30);
    press(1, 0, 0, 0);
    press(0, 1, 0, 0);
    chk("min_field", field, 3'd1);
    press(0, 0, 0, 1);
    chk("min_wrap", time_set, tp(10, 59, 30));
    nexts(5);
    commit_strobes("c2");
    chk("c2_time", time_set, tp(10, 59, 30));

    // Leap-year day clamp through month and year edits
    date_cur = dp(31, 1, 2020);
    press(1, 0, 0, 0);
    nexts(4);
    press(0, 0, 1, 0);
    chk("feb_leap_clamp", date_set, dp(29, 2, 2020));
    press(0, 1, 0, 0);
    press(0, 0, 0, 1);
    chk("feb_2019_clamp", date_set, dp(28, 2, 2019));
    press(0, 1, 0, 0);
    commit_strobes("c3");
    chk("c3_date", date_set, dp(28, 2, 2019));

    // Century rule: 2000 stepped to 2100, then direct century crossings
    date_cur = dp(29, 2, 2000);
    ow_mark = ow_seen;
    press(1, 0, 0, 0);
    nexts(5);
    for (int j = 0; j < 100; j++) press(0, 0, 1, 0);
    chk("year_2100", date_set, dp(28, 2, 2100));
    press(1, 0, 0, 0);
    chk("abort_editing", editing, 1'b0);
    chk("abort_keep", date_set, dp(28, 2, 2100));
    date_cur = dp(29, 2, 2099);
    press(1, 0, 0, 0); nexts(5); press(0, 0, 1, 0);
    chk("c2100_clamp", date_set, dp(28, 2, 2100));
    press(1, 0, 0, 0);
    date_cur = dp(29, 2, 2399);
    press(1, 0, 0, 0); nexts(5); press(0, 0, 1, 0);
    chk("c2400_keep", date_set, dp(29, 2, 2400));
    press(1, 0, 0, 0);
    chk("abort_no_strobe", ow_seen, ow_mark);

    // Day wrap both ways, out-of-range hour normalised, inc+dec ignored
    time_cur = tp(30, 5, 5); date_cur = dp(31, 1, 2021);
    press(1, 0, 0, 0);
    press(0, 0, 1, 0);
    chk("hour_norm", time_set, tp(0, 5, 5));
    press(0, 0, 1, 1);
    chk("incdec_hold", time_set, tp(0, 5, 5));
    nexts(3);
    press(0, 0, 1, 0);
    chk("day_wrap_up", date_set, dp(1, 1, 2021));
    press(0, 0, 0, 1);
    chk("day_wrap_dn", date_set, dp(31, 1, 2021));

    // Timeout: a button restarts the count, then TMO idle cycles abort
    repeat (TMO - 3) @(negedge clk);
    press(0, 0, 1, 1);
    repeat (TMO - 1) @(negedge clk);
    chk("tmo_before", editing, 1'b1);
    @(negedge clk);
    chk("tmo_abort", editing, 1'b0);
    chk("tmo_no_strobe", ow_seen, ow_mark);

    // Reset during the second strobe cycle
    press(1, 0, 0, 0);
    nexts(6);
    chk("rc_ow1", time_ow, 1'b1);
    @(posedge clk); #1;
    rst = 1; #1;
    chk("rc_ow_drop", {time_ow, date_ow, editing}, 3'b000);
    chk("rc_date", date_set, dp(1, 1, 0));
    chk("rc_time", time_set, 17'd0);
    @(negedge clk); rst = 0;
    @(negedge clk);
    chk("rc_idle", {time_ow, date_ow, editing}, 3'b000);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/clock_set_controller.md
Name: clock_set_controller

Overview:
- User-facing setting sequencer for the clockWork time counter and the date_module calendar counter.
- Snapshots the running time and date, then lets the user step through the six fields and increment or decrement each one with range wrap and day-of-month clamping.
- On commit, drives the packed overwrite buses and the time_ow/date_ow strobes into both counters.
- Sits between the debounced button logic and the two counters.

Parameters:
- OW_CYCLES, 4: number of cycles time_ow/date_ow stay high on commit. Must be ≥1 so the slow date clock can sample the strobe.
- EDIT_TIMEOUT, 100000000: idle cycles in EDIT before an automatic abort. Must be ≥1.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-high reset
- edit_btn  input  1  single-cycle pulse; enter edit mode, or abort when already editing
- next_btn  input  1  single-cycle pulse; advance to next field
- inc_btn  input  1  single-cycle pulse; increment current field
- dec_btn  input  1  single-cycle pulse; decrement current field
- time_cur  input  17  running time {hour[4:0],min[5:0],sec[5:0]}
- date_cur  input  21  running date {day[4:0],month[3:0],year[11:0]}
- time_set  output  17  overwrite value for clockWork
- date_set  output  21  overwrite value for date_module
- time_ow  output  1  time overwrite strobe
- date_ow  output  1  date overwrite strobe
- editing  output  1  high while in EDIT
- field  output  3  current field: 0 HOUR, 1 MIN, 2 SEC, 3 DAY, 4 MONTH, 5 YEAR

Behaviour:
- Clock and reset: single clock domain. rst is asynchronous and active-high and applies immediately, including mid-COMMIT, where both strobes drop at once.
- Reset values:
  - state IDLE; field 0; editing 0
  - time_ow 0; date_ow 0
  - time_set 0
  - date_set {5'd1,4'd1,12'd0}
  - timeout counter 0; commit counter 0
- States: IDLE, EDIT, COMMIT.
- IDLE:
  - edit_btn=1: capture time_cur/date_cur into the time_set/date_set shadow registers, set field=HOUR, go to EDIT the next cycle, editing=1.
  - All other buttons are ignored.
- EDIT, button priority per cycle is edit_btn > next_btn > inc/dec:
  - edit_btn: abort to IDLE; no strobes; shadow registers keep their edited contents.
  - next_btn: field+1. From YEAR, go to COMMIT with field back to 0.
  - inc_btn and dec_btn together: no change (both ignored).
  - Any button pulse clears the timeout counter.
  - Otherwise the counter increments. On reaching EDIT_TIMEOUT, abort to IDLE exactly as for edit_btn.
- Field ranges, wrapping in both directions:
  - hour 0..23
  - min 0..59; sec 0..59
  - day 1..dim(month,year)
  - month 1..12
  - year 0..4095 (natural 12-bit wrap)
- Day clamping:
  - Whenever month or year is modified and day > dim of the new month/year, day is set to the new dim in the same cycle.
  - An out-of-range snapshot is normalised as follows: hour/min/sec above max become 0 and day/month 0 become 1 on the first inc/dec of that field. Otherwise the value passes through unchanged.
- Leap-year rule: leap = (year%4==0) && (year%100!=0 || year%400==0).
- dim values:
  - 31: months 1, 3, 5, 7, 8, 10, 12
  - 30: months 4, 6, 9, 11
  - Month 2: 29 if leap, else 28
- COMMIT:
  - time_ow=date_ow=1 for exactly OW_CYCLES cycles, with time_set/date_set stable throughout; editing=0.
  - Then IDLE with both strobes 0.
  - All buttons are ignored during COMMIT.
- Outputs are registered: a button pulse in cycle n is visible on the outputs in cycle n+1.

Decomposition:
- Shared package:
  - field encodings FLD_HOUR..FLD_YEAR
  - widths TIME_W=17, DATE_W=21
  - field bit positions and range maxima (23, 59, 12)
- Sub-module month_length (combinational): inputs month[3:0] and year[11:0], output dim[4:0] including the leap logic. It is reusable later by date_module.

Test Plan:
- Hour wrap and commit:
  - Stimulus: time_cur=23:48:00, date_cur=15.01.2020; edit, inc, then next×6.
  - Required: time_set=00:48:00 and date_set=15.01.2020; time_ow/date_ow high for exactly 4 cycles, then 0; editing=0.
- Min wrap on decrement: time_cur=10:00:30; edit, next, dec → field=1 and min=59. Commit → time_set=10:59:30.
- Leap clamp:
  - Stimulus: date_cur=31.01.2020; edit, next×4, inc (month 2) → day=29.
  - Then next, dec (year 2019) → day=28.
  - Commit → date_set=28.02.2019.
- Century rule: date_cur=29.02.2000; set year to 2100 via inc → day clamps to 28; year 2400 keeps 29.
- Abort paths:
  - edit_btn in EDIT → IDLE with no strobe.
  - No buttons for EDIT_TIMEOUT cycles (use a small value in the bench) → IDLE with no strobe.
  - inc+dec in the same cycle → value unchanged.
- Reset mid-COMMIT: rst asserted in the 2nd strobe cycle → time_ow/date_ow drop immediately, state IDLE, date_set=01.01.0000.
